// File: rtl/fp32_div_seq_if.sv
// Operand/result bundle for the sequential FP32 divider.
// Optional status flags appear only when FP32_DIV_STATUS_EN is defined.
interface fp32_div_seq_if;
  logic        start;
  logic        num_sign;
  logic [7:0]  num_exp;
  logic [22:0] num_mant;
  logic        den_sign;
  logic [7:0]  den_exp;
  logic [22:0] den_mant;
  logic        busy;
  logic        done;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_mant;
`ifdef FP32_DIV_STATUS_EN
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output start, num_sign, num_exp, num_mant, den_sign, den_exp, den_mant,
    input  busy, done, out_sign, out_exp, out_mant, div_by_zero, invalid
  );

  modport slave (
    input  start, num_sign, num_exp, num_mant, den_sign, den_exp, den_mant,
    output busy, done, out_sign, out_exp, out_mant, div_by_zero, invalid
  );
`else
  modport master (
    output start, num_sign, num_exp, num_mant, den_sign, den_exp, den_mant,
    input  busy, done, out_sign, out_exp, out_mant
  );

  modport slave (
    input  start, num_sign, num_exp, num_mant, den_sign, den_exp, den_mant,
    output busy, done, out_sign, out_exp, out_mant
  );
`endif
endinterface

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single divider: restoring division, one quotient bit
// per cycle, truncation, flush-to-zero. Fixed 26-cycle start-to-done latency.
// Optional: define FP32_DIV_STATUS_EN to add div_by_zero / invalid flags.
//
// state | meaning
// IDLE  | waiting for start, operands latched on the accepting edge
// DIV   | 25 restoring-division steps, quotient MSB first
// NORM  | normalise, apply specials, register outputs, pulse done
module fp32_div_seq (
  input  logic           clk,
  input  logic           rst,
  fp32_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

  state_t             state_q, state_d;
  logic               accept, div_step, norm_step;

  logic [4:0]         cnt_q;
  logic [24:0]        rem_q;
  logic [23:0]        den_sig_q;
  logic [24:0]        quo_q;
  logic signed [9:0]  exp_q;
  logic               sign_q;
  logic               num_zero_q, num_inf_q, den_zero_q, den_inf_q;

  logic               done_q, out_sign_q;
  logic [7:0]         out_exp_q;
  logic [22:0]        out_mant_q;

  logic               rem_ge;
  logic [24:0]        rem_nxt;
  logic signed [9:0]  exp_norm;
  logic [22:0]        mant_norm;
  logic               is_inv, is_dbz;
  logic [7:0]         res_exp;
  logic [22:0]        res_mant;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state and step strobes; start is only looked at in IDLE
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    div_step  = 1'b0;
    norm_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt_q == 5'd0) state_d = NORM;
      end
      NORM: begin
        norm_step = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // one restoring step: subtract divisor when it fits, then shift remainder
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, den_sig_q});
    rem_nxt = rem_ge ? (rem_q - {1'b0, den_sig_q}) : rem_q;
  end

  // normalisation, range clamp and special-operand override
  always_comb begin
    if (quo_q[24]) begin
      exp_norm  = exp_q;
      mant_norm = quo_q[23:1];
    end else begin
      exp_norm  = exp_q - 10'sd1;
      mant_norm = quo_q[22:0];
    end

    if (exp_norm <= 10'sd0) begin
      res_exp  = 8'd0;
      res_mant = 23'd0;
    end else if (exp_norm >= 10'sd255) begin
      res_exp  = 8'd255;
      res_mant = 23'd0;
    end else begin
      res_exp  = exp_norm[7:0];
      res_mant = mant_norm;
    end

    is_inv = (num_zero_q && den_zero_q) || (num_inf_q && den_inf_q);
    is_dbz = den_zero_q && !num_zero_q;

    if (is_inv) begin
      res_exp  = 8'd255;
      res_mant = 23'h400000;
    end else if (is_dbz || num_inf_q) begin
      res_exp  = 8'd255;
      res_mant = 23'd0;
    end else if (den_inf_q || num_zero_q) begin
      res_exp  = 8'd0;
      res_mant = 23'd0;
    end
  end

`ifdef FP32_DIV_STATUS_EN
  logic dbz_q, inv_q;

  // status flags: cleared on accept, set on the NORM edge
  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= 1'b0;
      inv_q <= 1'b0;
    end else if (norm_step) begin
      dbz_q <= is_dbz && !is_inv;
      inv_q <= is_inv;
    end
  end

  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;
`endif

  // operand capture, division iterations and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      rem_q      <= 25'd0;
      den_sig_q  <= 24'd0;
      quo_q      <= 25'd0;
      exp_q      <= 10'sd0;
      sign_q     <= 1'b0;
      num_zero_q <= 1'b0;
      num_inf_q  <= 1'b0;
      den_zero_q <= 1'b0;
      den_inf_q  <= 1'b0;
      done_q     <= 1'b0;
      out_sign_q <= 1'b0;
      out_exp_q  <= 8'd0;
      out_mant_q <= 23'd0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q      <= 5'd24;
        rem_q      <= (bus.num_exp == 8'd0) ? 25'd0 : {2'b01, bus.num_mant};
        den_sig_q  <= (bus.den_exp == 8'd0) ? 24'd0 : {1'b1, bus.den_mant};
        quo_q      <= 25'd0;
        exp_q      <= $signed({2'b00, bus.num_exp}) - $signed({2'b00, bus.den_exp}) + 10'sd127;
        sign_q     <= bus.num_sign ^ bus.den_sign;
        num_zero_q <= (bus.num_exp == 8'd0);
        num_inf_q  <= (bus.num_exp == 8'd255);
        den_zero_q <= (bus.den_exp == 8'd0);
        den_inf_q  <= (bus.den_exp == 8'd255);
      end
      if (div_step) begin
        quo_q <= {quo_q[23:0], rem_ge};
        rem_q <= {rem_nxt[23:0], 1'b0};
        cnt_q <= cnt_q - 5'd1;
      end
      if (norm_step) begin
        done_q     <= 1'b1;
        out_sign_q <= sign_q;
        out_exp_q  <= res_exp;
        out_mant_q <= res_mant;
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.out_sign = out_sign_q;
  assign bus.out_exp  = out_exp_q;
  assign bus.out_mant = out_mant_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed-vector bench for fp32_div_seq with a queue scoreboard and a
// monitor that checks every done pulse, including its cycle of arrival.
module tb_fp32_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pcnt   = 0;

  fp32_div_seq_if bus();

  fp32_div_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        dbz;
    logic        inv;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk({x.name, ".sign"}, {31'd0, bus.out_sign}, {31'd0, x.s});
        chk({x.name, ".exp"}, {24'd0, bus.out_exp}, {24'd0, x.e});
        chk({x.name, ".mant"}, {9'd0, bus.out_mant}, {9'd0, x.m});
        chk({x.name, ".latency"}, pcnt, x.due);
`ifdef FP32_DIV_STATUS_EN
        chk({x.name, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, x.dbz});
        chk({x.name, ".inv"}, {31'd0, bus.invalid}, {31'd0, x.inv});
`endif
      end
    end
  end

  task automatic drive(input logic ns, input logic [7:0] ne, input logic [22:0] nm,
                       input logic ds, input logic [7:0] de, input logic [22:0] dm);
    bus.num_sign = ns; bus.num_exp = ne; bus.num_mant = nm;
    bus.den_sign = ds; bus.den_exp = de; bus.den_mant = dm;
  endtask

  task automatic push(input string nm, input logic s, input logic [7:0] e, input logic [22:0] m,
                      input logic dbz, input logic inv);
    exp_t x;
    x.name = nm; x.s = s; x.e = e; x.m = m; x.dbz = dbz; x.inv = inv;
    x.due  = pcnt + 27;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) chk({nm, ".timeout"}, 32'd1, 32'd0);
  endtask

  // issue one divide, scramble the inputs after acceptance, wait for completion
  task automatic run_div(input string nm,
                         input logic ns, input logic [7:0] ne, input logic [22:0] nm_,
                         input logic ds, input logic [7:0] de, input logic [22:0] dm,
                         input logic es, input logic [7:0] ee, input logic [22:0] em,
                         input logic edbz, input logic einv);
    @(negedge clk);
    drive(ns, ne, nm_, ds, de, dm);
    bus.start = 1'b1;
    push(nm, es, ee, em, edbz, einv);
    @(negedge clk);
    bus.start = 1'b0;
    drive(~ns, 8'h5A, 23'h7FFFFF, ~ds, 8'hA5, 23'h123456);
    chk({nm, ".busy"}, {31'd0, bus.busy}, 32'd1);
`ifdef FP32_DIV_STATUS_EN
    chk({nm, ".flags_clr"}, {30'd0, bus.div_by_zero, bus.invalid}, 32'd0);
`endif
    wait_idle(nm);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    drive(1'b0, 8'd0, 23'd0, 1'b0, 8'd0, 23'd0);
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.done", {31'd0, bus.done}, 32'd0);
    chk("rst.out", {bus.out_sign, bus.out_exp, bus.out_mant}, 32'd0);
    rst = 1'b0;

    run_div("six_by_two",  0, 129, 23'h400000, 0, 128, 23'h000000, 0, 128, 23'h400000, 0, 0);
    run_div("one_by_three",0, 127, 23'h000000, 0, 128, 23'h400000, 0, 125, 23'h2AAAAA, 0, 0);
    run_div("neg5_by_zero",1, 129, 23'h200000, 0,   0, 23'h000000, 1, 255, 23'h000000, 1, 0);
    run_div("underflow",   0,   1, 23'h000000, 0, 254, 23'h000000, 0,   0, 23'h000000, 0, 0);
    run_div("overflow",    0, 254, 23'h000000, 0,   1, 23'h000000, 0, 255, 23'h000000, 0, 0);
    run_div("neg6_by_two", 1, 129, 23'h400000, 0, 128, 23'h000000, 1, 128, 23'h400000, 0, 0);
    run_div("neg_equal",   1, 127, 23'h400000, 1, 127, 23'h400000, 0, 127, 23'h000000, 0, 0);
    run_div("one_by_1p25", 0, 127, 23'h000000, 0, 127, 23'h200000, 0, 126, 23'h4CCCCC, 0, 0);
    run_div("exp_min_ok",  0,   1, 23'h000000, 0, 127, 23'h000000, 0,   1, 23'h000000, 0, 0);
    run_div("exp_flush",   0,   1, 23'h000000, 0, 127, 23'h400000, 0,   0, 23'h000000, 0, 0);
    run_div("exp_max_ok",  0, 254, 23'h400000, 0, 127, 23'h400000, 0, 254, 23'h000000, 0, 0);
    run_div("exp_sat",     0, 254, 23'h400000, 0, 126, 23'h000000, 0, 255, 23'h000000, 0, 0);
    run_div("inf_by_two",  0, 255, 23'h000000, 0, 128, 23'h000000, 0, 255, 23'h000000, 0, 0);
    run_div("three_by_ninf",0,128, 23'h400000, 1, 255, 23'h000000, 1,   0, 23'h000000, 0, 0);
    run_div("nzero_by_5",  1,   0, 23'h000000, 0, 129, 23'h200000, 1,   0, 23'h000000, 0, 0);
    run_div("inf_by_ninf", 0, 255, 23'h000000, 1, 255, 23'h000000, 1, 255, 23'h400000, 0, 1);
    run_div("inf_by_zero", 0, 255, 23'h000000, 0,   0, 23'h000000, 0, 255, 23'h000000, 1, 0);

    // 0/0 with a second start pulse while busy: exactly one done, 0/0 result
    @(negedge clk);
    drive(0, 8'd0, 23'd0, 1, 8'd0, 23'd0);
    bus.start = 1'b1;
    push("zero_by_zero", 1, 8'd255, 23'h400000, 0, 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    drive(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("zero_by_zero");
    repeat (30) @(negedge clk);
    chk("ignored_start.busy", {31'd0, bus.busy}, 32'd0);

    // reset 10 cycles into a divide, with start held high during the reset edge
    @(negedge clk);
    drive(0, 8'd127, 23'd0, 0, 8'd128, 23'h400000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    chk("abort.busy", {31'd0, bus.busy}, 32'd0);
    chk("abort.done", {31'd0, bus.done}, 32'd0);
    chk("abort.out", {bus.out_sign, bus.out_exp, bus.out_mant}, 32'd0);
`ifdef FP32_DIV_STATUS_EN
    chk("abort.flags", {30'd0, bus.div_by_zero, bus.invalid}, 32'd0);
`endif
    rst = 1'b0;
    drive(0, 8'd129, 23'h400000, 0, 8'd128, 23'd0);
    push("after_abort", 0, 8'd128, 23'h400000, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("after_abort.busy", {31'd0, bus.busy}, 32'd1);
    wait_idle("after_abort");

    repeat (30) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
